// File: rtl/array_result_collector_pkg.sv
// Shared definitions for the compute-array row result collector.
// State encoding and payload width agreed with the array and stage controller.
package array_result_collector_pkg;

  localparam int unsigned ARC_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_DRAIN,
    ST_DONE
  } arc_state_e;

endpackage

// File: rtl/sync_fifo_reg.sv
// Synchronous FIFO with a registered head; a full FIFO accepts a push
// only when a pop happens in the same cycle.
module sync_fifo_reg #(
  parameter int W     = 33,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         ready,
  output logic         rvalid,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] rem;
  logic [W-1:0]  out_q, out_d;
  logic          vld_q, vld_d;
  logic          pop, wr_en;

  // Pointer/count update and next head selection.
  always_comb begin
    pop   = vld_q & ready;
    full  = (cnt_q == CW'(DEPTH));
    wr_en = push & (~full | pop);
    cnt_d = cnt_q + CW'(wr_en) - CW'(pop);
    wr_d  = wr_en ? wr_q + AW'(1) : wr_q;
    rd_d  = pop ? rd_q + AW'(1) : rd_q;
    rem   = cnt_q - CW'(pop);
    vld_d = (cnt_d != '0);
    out_d = '0;
    if (cnt_d != '0) begin
      if (rem == '0) out_d = wdata;
      else           out_d = mem_q[rd_d];
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= wdata;
  end

  // Pointers, occupancy and registered head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      out_q <= '0;
      vld_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
      vld_q <= vld_d;
    end
  end

  assign rvalid = vld_q;
  assign rdata  = out_q;
  assign empty  = ~vld_q;

endmodule

// File: rtl/array_result_collector.sv
// Collects one row's west-port beat stream per stage and re-emits it
// as AXI-Stream with tlast, reporting done/timeout/overflow.
module array_result_collector
  import array_result_collector_pkg::*;
#(
  parameter int DATA_W  = ARC_DATA_W,
  parameter int DEPTH   = 16,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stage_start,
  input  logic [CNT_W-1:0]  expected_cnt,
  input  logic              in_tvalid,
  input  logic [DATA_W-1:0] in_tdata,
  output logic              m_axis_tvalid,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic [CNT_W-1:0]  beat_cnt,
  output logic              stage_done,
  output logic              timeout_err,
  output logic              overflow
);

  localparam int IW = $clog2(TIMEOUT + 1);
  localparam int NW = CNT_W + 1;

  arc_state_e       state_q, state_d;
  logic             stage_q;
  logic [CNT_W-1:0] exp_q, exp_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [IW-1:0]    idle_q, idle_d;
  logic             tmo_q, tmo_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic             stage_rise, pop, beat, is_last;
  logic [NW-1:0]    nxt;
  logic             fifo_full, fifo_empty;
  logic [DATA_W:0]  fifo_rdata;

  // Stage FSM, beat accounting and sticky flags.
  always_comb begin
    stage_rise = stage_start & ~stage_q;
    pop        = m_axis_tvalid & m_axis_tready;
    beat       = (state_q == ST_COLLECT) & in_tvalid & ~stage_rise;
    nxt        = {1'b0, beat_cnt_q} + NW'(1);
    is_last    = (nxt == {1'b0, exp_q});
    state_d    = state_q;
    exp_d      = exp_q;
    beat_cnt_d = beat_cnt_q;
    idle_d     = idle_q;
    tmo_d      = tmo_q;
    ovf_d      = ovf_q;
    if (stage_rise) begin
      exp_d      = expected_cnt;
      beat_cnt_d = '0;
      idle_d     = '0;
      tmo_d      = 1'b0;
      ovf_d      = 1'b0;
      state_d    = ST_COLLECT;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_COLLECT: begin
          idle_d = in_tvalid ? '0 : idle_q + IW'(1);
          if (beat) begin
            if (~&beat_cnt_q) beat_cnt_d = beat_cnt_q + CNT_W'(1);
            if (fifo_full & ~pop) ovf_d = 1'b1;
          end
          if (beat & is_last) begin
            state_d = ST_DRAIN;
          end else if (exp_q == '0) begin
            state_d = ST_DRAIN;
          end else if (idle_d == IW'(TIMEOUT)) begin
            state_d = ST_DRAIN;
            tmo_d   = 1'b1;
          end
        end
        ST_DRAIN: if (fifo_empty) state_d = ST_DONE;
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
    done_d = (state_d == ST_DONE);
  end

  // Collector state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      stage_q    <= 1'b0;
      exp_q      <= '0;
      beat_cnt_q <= '0;
      idle_q     <= '0;
      tmo_q      <= 1'b0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      stage_q    <= stage_start;
      exp_q      <= exp_d;
      beat_cnt_q <= beat_cnt_d;
      idle_q     <= idle_d;
      tmo_q      <= tmo_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  sync_fifo_reg #(
    .W     (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (beat),
    .wdata  ({is_last, in_tdata}),
    .ready  (m_axis_tready),
    .rvalid (m_axis_tvalid),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign m_axis_tdata = fifo_rdata[DATA_W-1:0];
  assign m_axis_tlast = fifo_rdata[DATA_W];
  assign beat_cnt     = beat_cnt_q;
  assign stage_done   = done_q;
  assign timeout_err  = tmo_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_array_result_collector.sv
// Scoreboard bench for array_result_collector: expected beats queued at
// drive time, output beats captured on handshakes and compared per test.
module tb_array_result_collector;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stage_start = 1'b0;
  logic [15:0] expected_cnt = '0;
  logic        in_tvalid = 1'b0;
  logic [31:0] in_tdata = '0;
  logic        m_axis_tvalid;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic        m_axis_tready = 1'b0;
  logic [15:0] beat_cnt;
  logic        stage_done;
  logic        timeout_err;
  logic        overflow;

  logic [32:0] exp_q[$];
  logic [32:0] got_q[$];
  int          done_cnt = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  array_result_collector dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stage_start   (stage_start),
    .expected_cnt  (expected_cnt),
    .in_tvalid     (in_tvalid),
    .in_tdata      (in_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .beat_cnt      (beat_cnt),
    .stage_done    (stage_done),
    .timeout_err   (timeout_err),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_axis_tvalid && m_axis_tready)
        got_q.push_back({m_axis_tlast, m_axis_tdata});
      if (stage_done) done_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic open_stage(input logic [15:0] c);
    @(posedge clk); #1;
    stage_start = 1'b0;
    @(posedge clk); #1;
    stage_start  = 1'b1;
    expected_cnt = c;
    @(posedge clk); #1;
  endtask

  task automatic send_beat(input logic [31:0] d, input bit last, input bit keep);
    in_tvalid = 1'b1;
    in_tdata  = d;
    if (keep) exp_q.push_back({last, d});
    @(posedge clk); #1;
    in_tvalid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!stage_done && k < budget);
    cyc = stage_done ? k : -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #23;
    n_cmp++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, beat_cnt,
         stage_done, timeout_err, overflow} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got tvalid=%b tdata=%h beat_cnt=%0d done=%b tmo=%b ovf=%b, want all 0",
               m_axis_tvalid, m_axis_tdata, beat_cnt, stage_done, timeout_err, overflow);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_normal_flow();
    logic [31:0] v [4];
    int cyc;
    v[0] = 32'h3F80_0000; v[1] = 32'h4000_0000;
    v[2] = 32'h4040_0000; v[3] = 32'h4080_0000;
    exp_q.delete(); got_q.delete(); done_cnt = 0;
    m_axis_tready = 1'b1;
    open_stage(16'd4);
    for (int i = 0; i < 4; i++) send_beat(v[i], i == 3, 1'b1);
    wait_done(50, cyc);
    n_cmp++;
    if (cyc < 0) begin n_bad++; $display("FAIL normal_done: got no stage_done, want pulse"); end
    n_cmp++;
    if (got_q.size() !== exp_q.size()) begin
      n_bad++; $display("FAIL normal_count: got %0d beats, want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL normal_beat%0d: got %h, want %h", i, got_q[i], exp_q[i]);
      end
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (done_cnt !== 1 || stage_done !== 1'b0) begin
      n_bad++; $display("FAIL normal_pulse: got %0d pulses (done=%b), want 1 (done=0)", done_cnt, stage_done);
    end
    n_cmp++;
    if ({timeout_err, overflow} !== 2'b00 || beat_cnt !== 16'd4) begin
      n_bad++; $display("FAIL normal_flags: got tmo=%b ovf=%b cnt=%0d, want 0 0 4", timeout_err, overflow, beat_cnt);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    exp_q.delete(); got_q.delete(); done_cnt = 0;
    m_axis_tready = 1'b0;
    open_stage(16'd16);
    for (int i = 0; i < 16; i++) send_beat(32'hB000_0000 + i, i == 15, 1'b1);
    repeat (4) @(negedge clk);
    n_cmp++;
    if (overflow !== 1'b0 || beat_cnt !== 16'd16 || m_axis_tvalid !== 1'b1 || done_cnt !== 0) begin
      n_bad++; $display("FAIL bp_full: got ovf=%b cnt=%0d tvalid=%b done=%0d, want 0 16 1 0",
                        overflow, beat_cnt, m_axis_tvalid, done_cnt);
    end
    @(posedge clk); #1;
    m_axis_tready = 1'b1;
    wait_done(100, cyc);
    n_cmp++;
    if (cyc < 0 || got_q.size() !== 16) begin
      n_bad++; $display("FAIL bp_drain: got done_cyc=%0d beats=%0d, want done after 16 beats", cyc, got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL bp_beat%0d: got %h, want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_overflow();
    int cyc;
    exp_q.delete(); got_q.delete();
    m_axis_tready = 1'b0;
    open_stage(16'd20);
    for (int i = 0; i < 20; i++) send_beat(32'hC000_0000 + i, i == 19, i < 16);
    n_cmp++;
    if (overflow !== 1'b1 || beat_cnt !== 16'd20) begin
      n_bad++; $display("FAIL ovf_flag: got ovf=%b cnt=%0d, want 1 20", overflow, beat_cnt);
    end
    m_axis_tready = 1'b1;
    wait_done(100, cyc);
    n_cmp++;
    if (cyc < 0 || got_q.size() !== 16) begin
      n_bad++; $display("FAIL ovf_drain: got done_cyc=%0d beats=%0d, want done after 16 beats", cyc, got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL ovf_beat%0d: got %h, want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_timeout();
    int cyc;
    exp_q.delete(); got_q.delete();
    m_axis_tready = 1'b1;
    open_stage(16'd8);
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_bad++; $display("FAIL tmo_ovf_clear: got ovf=%b, want 0", overflow);
    end
    for (int i = 0; i < 3; i++) send_beat(32'hD000_0000 + i, 1'b0, 1'b1);
    wait_done(200, cyc);
    n_cmp++;
    if (cyc !== 66 || timeout_err !== 1'b1) begin
      n_bad++; $display("FAIL tmo_done: got cyc=%0d tmo=%b, want 66 1", cyc, timeout_err);
    end
    n_cmp++;
    if (got_q.size() !== 3) begin
      n_bad++; $display("FAIL tmo_count: got %0d beats, want 3", got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL tmo_beat%0d: got %h, want %h", i, got_q[i], exp_q[i]);
      end
    end
    exp_q.delete(); got_q.delete();
    open_stage(16'd1);
    n_cmp++;
    if (timeout_err !== 1'b0) begin
      n_bad++; $display("FAIL tmo_clear: got tmo=%b, want 0", timeout_err);
    end
    send_beat(32'hD100_0000, 1'b1, 1'b1);
    wait_done(50, cyc);
    n_cmp++;
    if (cyc < 0 || got_q.size() !== 1 || got_q[0] !== exp_q[0]) begin
      n_bad++; $display("FAIL tmo_next_stage: got cyc=%0d beats=%0d, want one beat %h", cyc, got_q.size(), exp_q[0]);
    end
  endtask

  task automatic test_zero_count();
    int cyc;
    exp_q.delete(); got_q.delete();
    m_axis_tready = 1'b1;
    @(posedge clk); #1;
    stage_start = 1'b0;
    @(posedge clk); #1;
    stage_start  = 1'b1;
    expected_cnt = 16'd0;
    wait_done(20, cyc);
    n_cmp++;
    if (cyc !== 4) begin
      n_bad++; $display("FAIL zero_latency: got done at sample %0d, want 4", cyc);
    end
    n_cmp++;
    if (got_q.size() !== 0) begin
      n_bad++; $display("FAIL zero_output: got %0d beats, want 0", got_q.size());
    end
  endtask

  task automatic test_reset_mid_stage();
    int cyc;
    exp_q.delete(); got_q.delete();
    m_axis_tready = 1'b0;
    open_stage(16'd8);
    for (int i = 0; i < 5; i++) send_beat(32'hE000_0000 + i, 1'b0, 1'b0);
    n_cmp++;
    if (m_axis_tvalid !== 1'b1 || beat_cnt !== 16'd5) begin
      n_bad++; $display("FAIL rst_pre: got tvalid=%b cnt=%0d, want 1 5", m_axis_tvalid, beat_cnt);
    end
    #2;
    rst_n = 1'b0;
    stage_start = 1'b0;
    #1;
    n_cmp++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, beat_cnt, overflow, timeout_err} !== '0) begin
      n_bad++; $display("FAIL rst_async: got tvalid=%b tdata=%h cnt=%0d, want all 0",
                        m_axis_tvalid, m_axis_tdata, beat_cnt);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_axis_tready = 1'b1;
    got_q.delete();
    open_stage(16'd2);
    send_beat(32'hF000_0000, 1'b0, 1'b1);
    send_beat(32'hF000_0001, 1'b1, 1'b1);
    wait_done(50, cyc);
    n_cmp++;
    if (cyc < 0 || got_q.size() !== 2) begin
      n_bad++; $display("FAIL rst_after: got cyc=%0d beats=%0d, want done with 2", cyc, got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL rst_beat%0d: got %h, want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_normal_flow();
    test_backpressure();
    test_overflow();
    test_timeout();
    test_zero_count();
    test_reset_mid_stage();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
